// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the multicycle MIPS control path: state encodings,
// opcodes, alu_op codes and the decoder's control-vector layout.
package multicycle_controller_pkg;

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_MEM_ADDR  = 4'd3;
  localparam logic [3:0] S_MEM_READ  = 4'd4;
  localparam logic [3:0] S_MEM_WB    = 4'd5;
  localparam logic [3:0] S_MEM_WRITE = 4'd6;
  localparam logic [3:0] S_R_EXEC    = 4'd7;
  localparam logic [3:0] S_R_WB      = 4'd8;
  localparam logic [3:0] S_BRANCH    = 4'd9;
  localparam logic [3:0] S_JUMP      = 4'd10;
  localparam logic [3:0] S_ADDI_EXEC = 4'd11;
  localparam logic [3:0] S_ADDI_WB   = 4'd12;
  localparam logic [3:0] S_ILLEGAL   = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_MTYPE = 2'b00;
  localparam logic [1:0] ALU_BTYPE = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_JTYPE = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRC_B_REG   = 2'b00;
  localparam logic [1:0] SRC_B_FOUR  = 2'b01;
  localparam logic [1:0] SRC_B_IMM   = 2'b10;
  localparam logic [1:0] SRC_B_SHIMM = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  // Dispatch target out of DECODE; anything unsupported is absorbed in ILLEGAL.
  function automatic logic [3:0] decode_target(input logic [5:0] op);
    logic [3:0] tgt;
    case (op)
      OP_LW, OP_SW: tgt = S_MEM_ADDR;
      OP_RTYPE:     tgt = S_R_EXEC;
      OP_BEQ:       tgt = S_BRANCH;
      OP_J:         tgt = S_JUMP;
      OP_ADDI:      tgt = S_ADDI_EXEC;
      default:      tgt = S_ILLEGAL;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/mc_output_decoder.sv
// Combinational control-output decode from the current FSM state; mem_ready
// only qualifies the FETCH and MEM_WRITE handshake outputs.
module mc_output_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_src,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal_op
);

  ctrl_t ctrl_s;

  // Per-state control vector; every field not named for a state stays 0.
  always_comb begin
    ctrl_s = '0;
    case (state)
      S_IDLE: begin
        ctrl_s = '0;
      end
      S_FETCH: begin
        ctrl_s.mem_read  = 1'b1;
        ctrl_s.i_or_d    = 1'b0;
        ctrl_s.alu_src_a = 1'b0;
        ctrl_s.alu_src_b = SRC_B_FOUR;
        ctrl_s.alu_op    = ALU_MTYPE;
        ctrl_s.pc_src    = PC_SRC_ALU;
        ctrl_s.ir_write  = mem_ready;
        ctrl_s.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl_s.alu_src_a = 1'b0;
        ctrl_s.alu_src_b = SRC_B_SHIMM;
        ctrl_s.alu_op    = ALU_MTYPE;
      end
      S_MEM_ADDR: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRC_B_IMM;
        ctrl_s.alu_op    = ALU_MTYPE;
      end
      S_MEM_READ: begin
        ctrl_s.mem_read = 1'b1;
        ctrl_s.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.mem_to_reg = 1'b1;
        ctrl_s.reg_dst    = 1'b0;
        ctrl_s.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_s.mem_write  = 1'b1;
        ctrl_s.i_or_d     = 1'b1;
        ctrl_s.instr_done = mem_ready;
      end
      S_R_EXEC: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRC_B_REG;
        ctrl_s.alu_op    = ALU_RTYPE;
      end
      S_R_WB: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.reg_dst    = 1'b1;
        ctrl_s.mem_to_reg = 1'b0;
        ctrl_s.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl_s.alu_src_a     = 1'b1;
        ctrl_s.alu_src_b     = SRC_B_REG;
        ctrl_s.alu_op        = ALU_BTYPE;
        ctrl_s.pc_write_cond = 1'b1;
        ctrl_s.pc_src        = PC_SRC_ALUOUT;
        ctrl_s.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl_s.pc_write   = 1'b1;
        ctrl_s.pc_src     = PC_SRC_JUMP;
        ctrl_s.alu_op     = ALU_JTYPE;
        ctrl_s.instr_done = 1'b1;
      end
      S_ADDI_EXEC: begin
        ctrl_s.alu_src_a = 1'b1;
        ctrl_s.alu_src_b = SRC_B_IMM;
        ctrl_s.alu_op    = ALU_MTYPE;
      end
      S_ADDI_WB: begin
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.reg_dst    = 1'b0;
        ctrl_s.mem_to_reg = 1'b0;
        ctrl_s.instr_done = 1'b1;
      end
      S_ILLEGAL: begin
        ctrl_s.illegal_op = 1'b1;
      end
      default: begin
        ctrl_s = '0;
      end
    endcase
  end

  assign pc_write      = ctrl_s.pc_write;
  assign pc_write_cond = ctrl_s.pc_write_cond;
  assign pc_src        = ctrl_s.pc_src;
  assign i_or_d        = ctrl_s.i_or_d;
  assign mem_read      = ctrl_s.mem_read;
  assign mem_write     = ctrl_s.mem_write;
  assign ir_write      = ctrl_s.ir_write;
  assign mem_to_reg    = ctrl_s.mem_to_reg;
  assign reg_dst       = ctrl_s.reg_dst;
  assign reg_write     = ctrl_s.reg_write;
  assign alu_src_a     = ctrl_s.alu_src_a;
  assign alu_src_b     = ctrl_s.alu_src_b;
  assign alu_op        = ctrl_s.alu_op;
  assign instr_done    = ctrl_s.instr_done;
  assign illegal_op    = ctrl_s.illegal_op;

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle MIPS datapath: state register and
// next-state logic here, output decode in mc_output_decoder.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_src,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal_op
);

  logic [3:0] state_r;
  logic [3:0] next_state_s;

  // State register; reset lands in IDLE so every enable drops immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; opcode is only consulted in DECODE and MEM_ADDR.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE:      next_state_s = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE:    next_state_s = decode_target(opcode);
      S_MEM_ADDR: begin
        if (opcode == OP_LW) begin
          next_state_s = S_MEM_READ;
        end else if (opcode == OP_SW) begin
          next_state_s = S_MEM_WRITE;
        end else begin
          next_state_s = S_ILLEGAL;
        end
      end
      S_MEM_READ: begin
        if (mem_ready) begin
          next_state_s = S_MEM_WB;
        end else begin
          next_state_s = S_MEM_READ;
        end
      end
      S_MEM_WB:    next_state_s = S_FETCH;
      S_MEM_WRITE: begin
        if (mem_ready) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_MEM_WRITE;
        end
      end
      S_R_EXEC:    next_state_s = S_R_WB;
      S_R_WB:      next_state_s = S_FETCH;
      S_BRANCH:    next_state_s = S_FETCH;
      S_JUMP:      next_state_s = S_FETCH;
      S_ADDI_EXEC: next_state_s = S_ADDI_WB;
      S_ADDI_WB:   next_state_s = S_FETCH;
      S_ILLEGAL:   next_state_s = S_ILLEGAL;
      // Unused encodings restart cleanly rather than lock up.
      default:     next_state_s = S_IDLE;
    endcase
  end

  mc_output_decoder u_output_decoder (
    .state         (state_r),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_src        (pc_src),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op)
  );

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle MIPS datapath; sequences fetch, decode, execute, memory and writeback for each instruction.
- Supported opcodes: R-type, lw, sw, beq, j, addi.
- Drives the datapath mux selects and write enables, plus the 2-bit alu_op consumed by alu_controller.
- Stalls on a single-port memory ready handshake.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word
- OP_SW, 6'b101011, store word
- OP_BEQ, 6'b000100, branch if equal
- OP_J, 6'b000010, jump
- OP_ADDI, 6'b001000, add immediate

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instruction register bits [31:26], valid from DECODE onward
- mem_ready  in  1  memory completed the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load gated by ALU zero (gating done in datapath)
- pc_src  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  register write data: 1 = MDR, 0 = ALUOut
- reg_dst  out  1  destination register: 1 = rd, 0 = rt
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted immediate
- alu_op  out  2  00 MTYPE, 01 BTYPE, 10 RTYPE, 11 JTYPE
- instr_done  out  1  one-cycle pulse on an instruction's final cycle
- illegal_op  out  1  sticky flag: unsupported opcode decoded

Behaviour:
- The reset and clock ports are one clock (clk) and an asynchronous, active-low reset (rst_n).
- Reset: state = IDLE asynchronously on rst_n low. In IDLE every output is 0, and alu_op = 00.
- IDLE -> FETCH unconditionally on the first clock edge after reset release.
- Outputs are decoded combinationally from the current state. mem_ready also gates the FETCH enables.
- Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write = pc_write = mem_ready.
  - Holds in FETCH while mem_ready=0; moves to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00.
  - Next state by opcode: LW/SW -> MEM_ADDR, RTYPE -> R_EXEC, BEQ -> BRANCH, J -> JUMP, ADDI -> ADDI_EXEC.
  - Any other opcode -> ILLEGAL.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state: LW -> MEM_READ, SW -> MEM_WRITE.
- MEM_READ: mem_read=1, i_or_d=1. Holds until mem_ready, then -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. Next state FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. Holds until mem_ready; instr_done = mem_ready; then -> FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next state R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01, instr_done=1. Next state FETCH.
- JUMP: pc_write=1, pc_src=10, alu_op=11, instr_done=1. Next state FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Next state ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next state FETCH.
- ILLEGAL: all enables 0, illegal_op=1. Absorbing state; only rst_n exits it.
- Latency with mem_ready tied high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles from FETCH entry to the instr_done cycle.
- Each cycle mem_ready is low in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- mem_read and mem_write are never both 1. No write enable is ever active outside the states listed above.
- Reset mid-instruction: abort immediately. All enables drop to 0 in the same cycle rst_n falls, with no partial register or memory write.
- mem_ready outside FETCH, MEM_READ and MEM_WRITE is ignored.
- opcode is sampled only in DECODE and MEM_ADDR.

Decomposition:
- Shared header constant_values.h gains:
  - state encodings (4-bit; IDLE = 0);
  - the opcode constants;
  - the alu_op codes MTYPE/BTYPE/RTYPE/JTYPE, already used by alu_controller.
- One sub-module, mc_output_decoder: combinational, taking state and mem_ready and producing all control outputs.
- The top module keeps the state register and the next-state logic.

Test Plan:
- Reset, then an R-type opcode, mem_ready=1 -> states IDLE, FETCH, DECODE, R_EXEC, R_WB; alu_op=10 in R_EXEC; reg_write=1 and reg_dst=1 in cycle 4; instr_done pulses once.
- lw with mem_ready low for 2 cycles in MEM_READ -> 7-cycle instruction; i_or_d=1 while stalled; mem_to_reg=1 and reg_write=1 only in MEM_WB.
- sw followed by beq, mem_ready=1 -> sw: mem_write=1 for exactly 1 cycle, reg_write never 1. beq: pc_write_cond=1, pc_src=01, alu_op=01 in cycle 3.
- j, then opcode 6'b111111 -> j: pc_write=1 with pc_src=10. Bad opcode: illegal_op=1, stays in ILLEGAL for 20 cycles, all enables 0; rst_n pulse clears it.
- rst_n asserted asynchronously mid-MEM_WRITE -> mem_write drops to 0 before the next clk edge; the controller restarts at FETCH 2 cycles after release.
